core_output_collector: RTL and testbench
========================================

Name: core_output_collector

Overview:
- Parametrised successor to the single-core output tap.
- Collects output spike events (destination-axon index plus valid strobe) from NUM_CHANNELS cores.
- Tags each event with its source channel and the current tick number, and arbitrates the events into one FIFO.
- Delivers words to the host side over a ready/valid handshake, so a slow consumer no longer loses spikes silently.

Parameters:
- NUM_CHANNELS, 4, number of core output taps (>=1)
- PACKET_WIDTH, 8, width of each channel's output packet (clog2 of NUM_OUTPUTS)
- TICK_WIDTH, 8, width of the tick-number tag (wraps)
- FIFO_DEPTH, 16, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- tick  in  1  one-cycle global tick pulse
- in_valid  in  NUM_CHANNELS  per-channel spike strobe, one cycle per event
- in_packet  in  NUM_CHANNELS*PACKET_WIDTH  channel c packet at [c*PACKET_WIDTH +: PACKET_WIDTH]
- out_data  out  TICK_WIDTH+CH_W+PACKET_WIDTH  {tick_tag, channel_id, packet}; CH_W = (NUM_CHANNELS>1) ? clog2(NUM_CHANNELS) : 1
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one event dropped
- clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, async):
  - tick counter = 0; all skid registers empty.
  - FIFO pointers = 0; fifo_count = 0; out_valid = 0.
  - out_data = 0; overflow = 0.
- Tick counter: increments modulo 2^TICK_WIDTH on each edge with tick=1. Events sampled on that same edge carry the pre-increment value.
- Skid stage, one entry per channel:
  - On an edge with in_valid[c]=1, skid[c] loads {tick_cnt, c, packet}.
  - skid[c] is loadable if it is empty, or if it is being granted on this same edge; in that case the new event replaces the drained one with no loss.
  - If skid[c] is full, not granted, and in_valid[c]=1: the new event is dropped, the old one is kept, and overflow is set.
- Arbiter:
  - Round-robin over occupied skids; at most one FIFO write per cycle.
  - Grant only when the FIFO is not full, or when a pop happens on the same edge (simultaneous push/pop at full is allowed).
  - Priority pointer advances to (granted index + 1) mod NUM_CHANNELS after each grant and holds when there is no grant.
- FIFO:
  - First-word-fall-through.
  - out_valid = (count != 0); out_data = head entry; out_data = 0 when empty.
  - Pop on out_valid && out_ready.
  - Pointers wrap at FIFO_DEPTH.
  - Push + pop on the same edge: count unchanged.
  - Pop when empty: ignored.
- Latency: in_valid at edge E -> skid at E -> FIFO write at E+1 -> out_valid high after E+1 (2 cycles, empty FIFO, no contention).
- Ordering: order is preserved within a channel. Across channels, order follows arbitration order.
- overflow:
  - Cleared by clr_overflow=1.
  - If a drop occurs on the same edge as clr_overflow, set wins.
- Throughput: 1 event/cycle sustained. Aggregate input above that rate overflows once the FIFO fills.

Optional Feature:
- Macro: CORE_OUTPUT_COLLECTOR_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count (16 bits), a saturating count (stops at 0xFFFF) of dropped events.
  - Reset to 0; cleared by clr_overflow.
  - Multiple drops on one edge add their total.
- Undefined: no drop_count port or logic; only the sticky overflow flag is present.

Test Plan:
- Reset/single event: rst low then high, out_ready=1; ch2 pulses packet 0x5A at tick_cnt 0 -> 2 cycles later out_valid=1, out_data={8'h00, 2'd2, 8'h5A}, one cycle wide; fifo_count returns to 0.
- Round-robin: all 4 channels valid in one cycle with packets 0x10..0x13, out_ready=1 -> FIFO words emerge in channel order 0,1,2,3 on 4 consecutive cycles; no overflow.
- Backpressure/full: out_ready=0; 16 events on ch0 over 16 separate cycles -> fifo_count=16. A 17th event stays in skid0 and an 18th is dropped -> overflow=1 (drop_count=1 with the macro). Raise out_ready -> all 17 retained events emerge in order.
- Tick tagging/wrap: 256 tick pulses -> counter wraps to 0. An event coincident with tick pulse #3 carries tag 2; the next event carries tag 3.
- Simultaneous push/pop at full: FIFO at 16 entries, out_ready=1 and skid0 occupied -> fifo_count stays 16 for that cycle and the head advances.
- Async reset mid-stream: rst dropped asynchronously while FIFO holds 5 entries and skids hold 2 -> out_valid, fifo_count and overflow go to 0 immediately, without waiting for a clock edge; no stale words appear after release.

Source files
------------

// File: rtl/core_output_collector.sv
// Multi-channel spike output collector: per-channel skid, round-robin arbiter, FWFT FIFO with ready/valid.
// Optional CORE_OUTPUT_COLLECTOR_DROP_COUNT_EN adds a saturating 16-bit drop_count output.
module core_output_collector #(
  parameter int NUM_CHANNELS = 4,
  parameter int PACKET_WIDTH = 8,
  parameter int TICK_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int DW   = TICK_WIDTH + CH_W + PACKET_WIDTH,
  localparam int AW   = $clog2(FIFO_DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tick,
  input  logic [NUM_CHANNELS-1:0]          in_valid,
  input  logic [NUM_CHANNELS*PACKET_WIDTH-1:0] in_packet,
  output logic [DW-1:0]                    out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CW-1:0]                    fifo_count,
  output logic                             overflow,
  input  logic                             clr_overflow
`ifdef CORE_OUTPUT_COLLECTOR_DROP_COUNT_EN
  ,
  output logic [15:0]                      drop_count
`endif
);

  localparam int DCW = $clog2(NUM_CHANNELS + 1);

  logic [TICK_WIDTH-1:0] tick_q, tick_d;
  logic                  skid_vld_q [NUM_CHANNELS];
  logic                  skid_vld_d [NUM_CHANNELS];
  logic [DW-1:0]         skid_data_q [NUM_CHANNELS];
  logic [DW-1:0]         skid_data_d [NUM_CHANNELS];
  logic [CH_W-1:0]       rr_q, rr_d;
  logic [DW-1:0]         mem_q [FIFO_DEPTH];
  logic [DW-1:0]         mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  pop_s, full_s, can_push_s;
  logic                  grant_vld_s;
  logic [CH_W-1:0]       grant_idx_s;
  logic [DCW-1:0]        drops_s;

  assign pop_s      = (count_q != {CW{1'b0}}) && out_ready;
  assign full_s     = (count_q == CW'(FIFO_DEPTH));
  // A pop on the same edge frees the slot, so a full FIFO can still accept a push.
  assign can_push_s = !full_s || pop_s;

  // Round-robin search starting at the priority pointer.
  always_comb begin : arb_comb
    int sum;
    logic [CH_W-1:0] cand;
    grant_vld_s = 1'b0;
    grant_idx_s = {CH_W{1'b0}};
    sum  = 0;
    cand = {CH_W{1'b0}};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum = int'(rr_q) + i;
      if (sum >= NUM_CHANNELS) begin
        sum = sum - NUM_CHANNELS;
      end else begin
        sum = sum;
      end
      cand = CH_W'(sum);
      if (!grant_vld_s && skid_vld_q[cand] && can_push_s) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (grant_vld_s) begin
      rr_d = (int'(grant_idx_s) == NUM_CHANNELS - 1) ? {CH_W{1'b0}} : grant_idx_s + CH_W'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Skid loading; a skid being granted this edge is free to take the new event.
  always_comb begin
    logic keep;
    drops_s = {DCW{1'b0}};
    keep    = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      keep = skid_vld_q[c] && !(grant_vld_s && (grant_idx_s == CH_W'(c)));
      skid_vld_d[c]  = keep;
      skid_data_d[c] = skid_data_q[c];
      if (in_valid[c]) begin
        if (keep) begin
          drops_s = drops_s + DCW'(1);
        end else begin
          skid_vld_d[c]  = 1'b1;
          skid_data_d[c] = {tick_q, CH_W'(c), in_packet[c*PACKET_WIDTH +: PACKET_WIDTH]};
        end
      end else begin
        skid_vld_d[c] = keep;
      end
    end
  end

  // FIFO pointers, occupancy, storage, tick counter and sticky overflow.
  always_comb begin
    mem_d = mem_q;
    if (grant_vld_s) begin
      mem_d[wr_ptr_q] = skid_data_q[grant_idx_s];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({grant_vld_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    tick_d     = tick ? tick_q + TICK_WIDTH'(1) : tick_q;
    overflow_d = (drops_s != {DCW{1'b0}}) ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q     <= {TICK_WIDTH{1'b0}};
      rr_q       <= {CH_W{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        skid_vld_q[c]  <= 1'b0;
        skid_data_q[c] <= {DW{1'b0}};
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      tick_q      <= tick_d;
      rr_q        <= rr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      mem_q       <= mem_d;
    end
  end

  assign out_valid  = (count_q != {CW{1'b0}});
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : {DW{1'b0}};
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

`ifdef CORE_OUTPUT_COLLECTOR_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum_s;

  // Saturating drop counter; a clear on a drop edge restarts from the new drops.
  always_comb begin
    drop_sum_s = {1'b0, (clr_overflow ? 16'h0000 : drop_cnt_q)} + 17'(drops_s);
    drop_cnt_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= 16'h0000;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_core_output_collector.sv
// Self-checking bench for core_output_collector: directed scenarios plus randomized traffic vs a queue model.
module tb_core_output_collector;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int TW = 8;
  localparam int D  = 16;
  localparam int DW = 18;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            tick = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N*PW-1:0] in_packet = '0;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [4:0]      fifo_count;
  logic            overflow;
  logic            clr_overflow = 1'b0;
`ifdef CORE_OUTPUT_COLLECTOR_DROP_COUNT_EN
  logic [15:0]     drop_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_tick;
  bit            m_sv [N];
  logic [DW-1:0] m_sd [N];
  int            m_rr;
  logic [DW-1:0] mq [$];
  bit            m_ovf;
  int            m_dc;

  core_output_collector dut (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_packet(in_packet),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow)
`ifdef CORE_OUTPUT_COLLECTOR_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_tick = 0; m_rr = 0; m_ovf = 0; m_dc = 0;
    for (int c = 0; c < N; c++) begin m_sv[c] = 0; m_sd[c] = '0; end
    mq.delete();
  endtask

  task automatic model_edge();
    bit pop; int g; int drops; int c;
    pop = (mq.size() != 0) && out_ready;
    g = -1;
    if (mq.size() < D || pop)
      for (int i = 0; i < N; i++) begin
        c = (m_rr + i) % N;
        if (g < 0 && m_sv[c]) g = c;
      end
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin mq.push_back(m_sd[g]); m_sv[g] = 0; m_rr = (g + 1) % N; end
    drops = 0;
    for (int k = 0; k < N; k++)
      if (in_valid[k]) begin
        if (m_sv[k]) drops++;
        else begin m_sv[k] = 1; m_sd[k] = {8'(m_tick), 2'(k), in_packet[k*PW +: PW]}; end
      end
    if (clr_overflow) begin m_ovf = 0; m_dc = 0; end
    if (drops != 0) m_ovf = 1;
    m_dc = (m_dc + drops > 65535) ? 65535 : m_dc + drops;
    if (tick) m_tick = (m_tick + 1) % 256;
  endtask

  function automatic logic [DW-1:0] exp_data();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    in_valid = '0; in_packet = '0; tick = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic apply_reset();
    set_idle();
    @(negedge clk); rst = 1'b0; model_reset();
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_reset();
    set_idle(); out_ready = 1'b1; model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_tests++; if (out_data !== 18'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single_event();
    out_ready = 1'b1;
    in_valid = 4'b0100; in_packet = 32'h005A_0000;
    step(); set_idle();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1 valid got %b want 0", out_valid); end
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_lat2 valid got %b want 1", out_valid); end
    n_tests++; if (out_data !== 18'h0025A) begin n_fail++; $display("FAIL single_data got %h want 0025a", out_data); end
    n_tests++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL single_model got %h want %h", out_data, exp_data()); end
    step();
    n_tests++; if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL single_width valid %b count %0d want 0 0", out_valid, fifo_count); end
  endtask

  task automatic test_round_robin();
    logic [1:0] ch; logic [7:0] pk;
    apply_reset(); out_ready = 1'b1;
    in_valid = 4'hF; in_packet = 32'h1312_1110;
    step(); set_idle();
    for (int k = 0; k < 4; k++) begin
      step();
      ch = out_data[9:8]; pk = out_data[7:0];
      n_tests++; if (out_valid !== 1'b1 || ch !== 2'(k) || pk !== 8'(8'h10 + k)) begin
        n_fail++; $display("FAIL rr_order[%0d] valid %b ch %0d pkt %h want 1 %0d %h", k, out_valid, ch, pk, k, 8'h10 + k);
      end
    end
    step();
    n_tests++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rr_end valid %b ovf %b want 0 0", out_valid, overflow); end
  endtask

  task automatic test_backpressure();
    apply_reset(); out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      in_valid = 4'b0001; in_packet = {24'h0, (i < 16) ? 8'(8'h20 + i) : 8'(8'h30 + i - 16)};
      step();
    end
    set_idle(); step();
    n_tests++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL bp_count got %0d want 16", fifo_count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b want 1", overflow); end
    n_tests++; if (out_data !== exp_data() || out_data[7:0] !== 8'h20) begin n_fail++; $display("FAIL bp_head got %h want %h", out_data, exp_data()); end
`ifdef CORE_OUTPUT_COLLECTOR_DROP_COUNT_EN
    n_tests++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL bp_drop_count got %0d want 1", drop_count); end
`endif
  endtask

  task automatic test_push_pop_at_full();
    logic [7:0] want;
    out_ready = 1'b1;
    step();
    n_tests++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL pp_count got %0d want 16", fifo_count); end
    for (int j = 0; j < 16; j++) begin
      want = (j < 15) ? 8'(8'h21 + j) : 8'h30;
      n_tests++; if (out_valid !== 1'b1 || out_data[7:0] !== want || out_data !== exp_data()) begin
        n_fail++; $display("FAIL pp_drain[%0d] got %h want pkt %h model %h", j, out_data, want, exp_data());
      end
      step();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty valid got %b want 0", out_valid); end
    clr_overflow = 1'b1; step(); set_idle();
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got %b want 0", overflow); end
  endtask

  task automatic test_tick_wrap();
    logic [7:0] tag;
    apply_reset(); out_ready = 1'b1;
    tick = 1'b1; step(); step();
    in_valid = 4'b0010; in_packet = 32'h0000_A100; step();
    set_idle(); step();
    tag = out_data[17:10];
    n_tests++; if (tag !== 8'd2 || out_data !== exp_data()) begin n_fail++; $display("FAIL tick3_tag got %0d want 2", tag); end
    in_valid = 4'b0010; in_packet = 32'h0000_A200; step();
    set_idle(); step();
    tag = out_data[17:10];
    n_tests++; if (tag !== 8'd3 || out_data !== exp_data()) begin n_fail++; $display("FAIL next_tag got %0d want 3", tag); end
    tick = 1'b1;
    repeat (253) step();
    set_idle();
    in_valid = 4'b1000; in_packet = 32'hBB00_0000; step();
    set_idle(); step();
    tag = out_data[17:10];
    n_tests++; if (tag !== 8'd0 || out_data !== exp_data()) begin n_fail++; $display("FAIL wrap_tag got %0d want 0", tag); end
  endtask

  task automatic test_random();
    int thr;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      thr = ((cyc / 300) % 4 + 1) * 20;
      for (int c = 0; c < N; c++) in_valid[c] = ($urandom_range(99) < thr);
      in_packet    = $urandom;
      tick         = ($urandom_range(7) == 0);
      out_ready    = ((cyc / 150) % 3 == 2) ? ($urandom_range(9) == 0) : ($urandom_range(3) != 0);
      clr_overflow = ($urandom_range(49) == 0);
      step();
      n_tests++; if (out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d got %b want %b", cyc, out_valid, mq.size() != 0); end
      n_tests++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data@%0d got %h want %h", cyc, out_data, exp_data()); end
      n_tests++; if (fifo_count !== 5'(mq.size())) begin n_fail++; $display("FAIL rnd_count@%0d got %0d want %0d", cyc, fifo_count, mq.size()); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d got %b want %b", cyc, overflow, m_ovf); end
`ifdef CORE_OUTPUT_COLLECTOR_DROP_COUNT_EN
      n_tests++; if (drop_count !== 16'(m_dc)) begin n_fail++; $display("FAIL rnd_drop_count@%0d got %0d want %0d", cyc, drop_count, m_dc); end
`endif
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    apply_reset(); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 4'b0010; in_packet = {16'h0, 8'(8'h40 + i), 8'h0}; step();
    end
    set_idle(); step();
    in_valid = 4'b1001; in_packet = 32'h7700_0066; step();
    set_idle();
    n_tests++; if (fifo_count !== 5'd5) begin n_fail++; $display("FAIL ar_pre_count got %0d want 5", fifo_count); end
    #2; rst = 1'b0; model_reset();
    #1;
    n_tests++; if (out_valid !== 1'b0 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate valid %b count %0d ovf %b want 0 0 0", out_valid, fifo_count, overflow);
    end
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++; if (out_valid !== 1'b0 || out_data !== 18'h0) begin n_fail++; $display("FAIL ar_stale[%0d] valid %b data %h want 0 0", i, out_valid, out_data); end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_round_robin();
    test_backpressure();
    test_push_pop_at_full();
    test_tick_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
